// File: rtl/reorder_buffer.sv
// Circular in-order-retire reorder buffer: tail allocation on dispatch, CDB completion by index,
// head retirement into the architectural register file, and full flush on a mispredicted head.
module reorder_buffer #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ROB_SIZE    = 8,
    parameter int unsigned ROB_IDX_LEN = 3
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [XLEN-1:0]        i_pc,
    input  logic                   i_dispatch_enable,
    input  logic [4:0]             i_dest_reg_idx,
    input  logic                   i_complete_enable,
    input  logic [ROB_IDX_LEN-1:0] i_complete_rob_entry,
    input  logic [XLEN-1:0]        i_value,
    input  logic                   i_wrong_pred,
    input  logic [ROB_IDX_LEN-1:0] i_require_entry_idx,
    output logic                   o_rob_full,
    output logic                   o_rob_empty,
    output logic                   o_retire_valid,
    output logic                   o_dest_valid,
    output logic [4:0]             o_dest_reg,
    output logic [XLEN-1:0]        o_dest_value,
    output logic                   o_squash_at_head,
    output logic [XLEN-1:0]        o_required_value,
    output logic [ROB_IDX_LEN-1:0] o_rob_head,
    output logic [ROB_IDX_LEN-1:0] o_rob_tail,
    output logic [ROB_IDX_LEN:0]   o_rob_counter
);

    localparam logic [ROB_IDX_LEN-1:0] IdxOne  = ROB_IDX_LEN'(1);
    localparam logic [ROB_IDX_LEN:0]   CntOne  = (ROB_IDX_LEN + 1)'(1);
    localparam logic [ROB_IDX_LEN:0]   CntFull = (ROB_IDX_LEN + 1)'(ROB_SIZE);

    logic [ROB_SIZE-1:0]    r_valid;
    logic [ROB_SIZE-1:0]    r_complete;
    logic [ROB_SIZE-1:0]    r_mispred;
    logic [XLEN-1:0]        r_pc    [ROB_SIZE];
    logic [4:0]             r_dest  [ROB_SIZE];
    logic [XLEN-1:0]        r_value [ROB_SIZE];
    logic [ROB_IDX_LEN-1:0] r_head;
    logic [ROB_IDX_LEN-1:0] r_tail;
    logic [ROB_IDX_LEN:0]   r_counter;

    logic                   w_full;
    logic                   w_retire_valid;
    logic                   w_squash;
    logic                   w_dispatch_ok;
    logic                   w_complete_ok;
    logic [ROB_IDX_LEN:0]   w_counter_next;
    logic                   w_unused_pc;

    assign w_full         = (r_counter == CntFull);
    assign w_retire_valid = r_valid[r_head] && r_complete[r_head];
    assign w_squash       = w_retire_valid && r_mispred[r_head];
    assign w_dispatch_ok  = i_dispatch_enable && !w_full && !w_squash;
    // A completion aimed at the entry retiring this cycle has nothing left to update.
    assign w_complete_ok  = i_complete_enable && r_valid[i_complete_rob_entry] &&
                            !(w_retire_valid && (i_complete_rob_entry == r_head));

    // PC is held per entry for recovery logic; nothing on this port list consumes it yet.
    assign w_unused_pc = ^r_pc[r_head];

    always_comb begin
        w_counter_next = r_counter;
        if (w_dispatch_ok && !w_retire_valid) begin
            w_counter_next = r_counter + CntOne;
        end else if (!w_dispatch_ok && w_retire_valid) begin
            w_counter_next = r_counter - CntOne;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid    <= '0;
            r_complete <= '0;
            r_mispred  <= '0;
            r_pc       <= '{default: '0};
            r_dest     <= '{default: '0};
            r_value    <= '{default: '0};
            r_head     <= '0;
            r_tail     <= '0;
            r_counter  <= '0;
        end else if (w_squash) begin
            r_valid    <= '0;
            r_complete <= '0;
            r_mispred  <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_counter  <= '0;
        end else begin
            if (w_complete_ok) begin
                r_complete[i_complete_rob_entry] <= 1'b1;
                r_mispred[i_complete_rob_entry]  <= i_wrong_pred;
                r_value[i_complete_rob_entry]    <= i_value;
            end
            if (w_retire_valid) begin
                r_valid[r_head]    <= 1'b0;
                r_complete[r_head] <= 1'b0;
                r_mispred[r_head]  <= 1'b0;
                r_head             <= r_head + IdxOne;
            end
            if (w_dispatch_ok) begin
                r_valid[r_tail]    <= 1'b1;
                r_complete[r_tail] <= 1'b0;
                r_mispred[r_tail]  <= 1'b0;
                r_pc[r_tail]       <= i_pc;
                r_dest[r_tail]     <= i_dest_reg_idx;
                r_value[r_tail]    <= '0;
                r_tail             <= r_tail + IdxOne;
            end
            r_counter <= w_counter_next;
        end
    end

    always_comb begin
        o_required_value = '0;
        if (i_complete_enable && (i_complete_rob_entry == i_require_entry_idx)) begin
            o_required_value = i_value;
        end else if (r_valid[i_require_entry_idx] && r_complete[i_require_entry_idx]) begin
            o_required_value = r_value[i_require_entry_idx];
        end
    end

    assign o_rob_full       = w_full;
    assign o_rob_empty      = (r_counter == '0);
    assign o_retire_valid   = w_retire_valid;
    assign o_dest_valid     = w_retire_valid && (r_dest[r_head] != 5'd0);
    assign o_dest_reg       = w_retire_valid ? r_dest[r_head] : 5'd0;
    assign o_dest_value     = w_retire_valid ? r_value[r_head] : '0;
    assign o_squash_at_head = w_squash;
    assign o_rob_head       = r_head;
    assign o_rob_tail       = r_tail;
    assign o_rob_counter    = r_counter;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a program-order queue model predicts each cycle's outputs,
// a negedge monitor pops and compares them.
module tb_reorder_buffer;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic        dispatch_enable;
    logic [4:0]  dest_reg_idx;
    logic        complete_enable;
    logic [2:0]  complete_rob_entry;
    logic [31:0] value;
    logic        wrong_pred;
    logic [2:0]  require_entry_idx;
    logic        rob_full;
    logic        rob_empty;
    logic        retire_valid;
    logic        dest_valid;
    logic [4:0]  dest_reg;
    logic [31:0] dest_value;
    logic        squash_at_head;
    logic [31:0] required_value;
    logic [2:0]  rob_head;
    logic [2:0]  rob_tail;
    logic [3:0]  rob_counter;

    reorder_buffer dut (
        .i_clock             (clock),
        .i_reset             (reset),
        .i_pc                (pc),
        .i_dispatch_enable   (dispatch_enable),
        .i_dest_reg_idx      (dest_reg_idx),
        .i_complete_enable   (complete_enable),
        .i_complete_rob_entry(complete_rob_entry),
        .i_value             (value),
        .i_wrong_pred        (wrong_pred),
        .i_require_entry_idx (require_entry_idx),
        .o_rob_full          (rob_full),
        .o_rob_empty         (rob_empty),
        .o_retire_valid      (retire_valid),
        .o_dest_valid        (dest_valid),
        .o_dest_reg          (dest_reg),
        .o_dest_value        (dest_value),
        .o_squash_at_head    (squash_at_head),
        .o_required_value    (required_value),
        .o_rob_head          (rob_head),
        .o_rob_tail          (rob_tail),
        .o_rob_counter       (rob_counter)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  dest;
        bit          done;
        bit          mis;
        logic [31:0] val;
    } ent_t;

    typedef struct {
        bit          full;
        bit          empty;
        bit          rv;
        bit          dv;
        bit          sq;
        logic [4:0]  dreg;
        logic [31:0] dval;
        logic [31:0] req;
        logic [2:0]  head;
        logic [2:0]  tail;
        logic [3:0]  cnt;
    } exp_t;

    // Model: live instructions in program order; rob[0] sits in slot m_head.
    ent_t rob[$];
    int   m_head;
    exp_t exp_q[$];
    int   total;
    int   bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic step(input bit rst, input bit de, input logic [31:0] p, input logic [4:0] dst,
                        input bit ce, input logic [2:0] cidx, input logic [31:0] val,
                        input bit wp, input logic [2:0] ridx);
        exp_t e;
        int   cnt;
        int   k;
        reset              = rst;
        dispatch_enable    = de;
        pc                 = p;
        dest_reg_idx       = dst;
        complete_enable    = ce;
        complete_rob_entry = cidx;
        value              = val;
        wrong_pred         = wp;
        require_entry_idx  = ridx;

        cnt     = rob.size();
        e.cnt   = 4'(cnt);
        e.full  = (cnt == 8);
        e.empty = (cnt == 0);
        e.head  = 3'(m_head);
        e.tail  = 3'((m_head + cnt) % 8);
        e.rv    = (cnt > 0) && rob[0].done;
        e.sq    = e.rv && rob[0].mis;
        e.dreg  = e.rv ? rob[0].dest : 5'd0;
        e.dval  = e.rv ? rob[0].val : 32'd0;
        e.dv    = e.rv && (rob[0].dest != 5'd0);
        k       = (int'(ridx) - m_head + 8) % 8;
        if (ce && (cidx == ridx)) e.req = val;
        else if (k < cnt && rob[k].done) e.req = rob[k].val;
        else e.req = 32'd0;
        exp_q.push_back(e);

        if (rst || e.sq) begin
            rob.delete();
            m_head = 0;
        end else begin
            k = (int'(cidx) - m_head + 8) % 8;
            if (ce && k < cnt && !(e.rv && k == 0)) begin
                rob[k].done = 1'b1;
                rob[k].mis  = wp;
                rob[k].val  = val;
            end
            if (e.rv) begin
                void'(rob.pop_front());
                m_head = (m_head + 1) % 8;
            end
            if (de && cnt < 8) rob.push_back('{pc: p, dest: dst, done: 1'b0, mis: 1'b0, val: 0});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic [2:0] ridx);
        step(0, 0, 0, 0, 0, 0, 0, 0, ridx);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rob_full", 32'(rob_full), 32'(e.full));
                chk("rob_empty", 32'(rob_empty), 32'(e.empty));
                chk("retire_valid", 32'(retire_valid), 32'(e.rv));
                chk("dest_valid", 32'(dest_valid), 32'(e.dv));
                chk("dest_reg", 32'(dest_reg), 32'(e.dreg));
                chk("dest_value", dest_value, e.dval);
                chk("squash_at_head", 32'(squash_at_head), 32'(e.sq));
                chk("required_value", required_value, e.req);
                chk("rob_head", 32'(rob_head), 32'(e.head));
                chk("rob_tail", 32'(rob_tail), 32'(e.tail));
                chk("rob_counter", 32'(rob_counter), 32'(e.cnt));
            end
        end
    end

    initial begin
        int          cnt;
        logic [2:0]  ci;
        total = 0;
        bad = 0;
        m_head = 0;
        reset = 1'b1;
        dispatch_enable = 1'b0;
        pc = '0;
        dest_reg_idx = '0;
        complete_enable = 1'b0;
        complete_rob_entry = '0;
        value = '0;
        wrong_pred = 1'b0;
        require_entry_idx = '0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state, three dispatches, out-of-order completion, first retirement.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        step(0, 1, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 2, 2, 0, 0, 0, 0, 0);
        step(0, 1, 3, 3, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 2, 1, 0, 2);
        idle(2);
        step(0, 0, 0, 0, 1, 0, 156, 0, 0);
        idle(0);
        idle(1);

        // Fill to capacity, one extra dispatch, then sustained complete-head with dispatch.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 32'(100 + i), 5'(i + 1), 0, 0, 0, 0, 3'(i));
        idle(0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 32'(200 + i), 5'(i), 1, 3'(m_head), 32'(1000 + i), 0, 3'(m_head));
        end

        // Mispredicted head: squash cycle drops a concurrent dispatch and completion.
        for (int i = 0; i < 3; i++) idle(0);
        step(0, 0, 0, 0, 1, 3'(m_head), 32'h0bad, 1, 3'(m_head));
        step(0, 1, 77, 7, 1, 3'((m_head + 1) % 8), 32'h55, 0, 0);
        idle(0);
        step(0, 1, 78, 8, 0, 0, 0, 0, 0);
        idle(0);

        for (int n = 0; n < 3000; n++) begin
            cnt = rob.size();
            if (cnt > 0 && $urandom_range(0, 9) < 7) ci = 3'((m_head + $urandom_range(0, cnt - 1)) % 8);
            else ci = 3'($urandom);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, $urandom, 5'($urandom),
                 $urandom_range(0, 1) == 1, ci, $urandom, $urandom_range(0, 15) == 0, 3'($urandom));
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
